// File: rtl/riscv_i32_trace_decompression_if.sv
// +----------------------------------------------------------------------------+
// | riscv_i32_trace_decompression_if                                           |
// | Compressed nybble-stream input and packed trace event outputs.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface riscv_i32_trace_decompression_if;
  logic [4:0]  compressed_trace__valid;
  logic [63:0] compressed_trace__data;
  logic        compressed_trace_ready;

  logic        packed_trace__seq_valid;
  logic [2:0]  packed_trace__seq;
  logic        packed_trace__nonseq_valid;
  logic [1:0]  packed_trace__nonseq;
  logic        packed_trace__bkpt_valid;
  logic [3:0]  packed_trace__bkpt;
  logic        packed_trace__data_valid;
  logic        packed_trace__data_reason;
  logic [39:0] packed_trace__data;
  logic [3:0]  packed_trace__compressed_data_num_bytes;
  logic [2:0]  packed_trace__compressed_data_nybble;

  // Producer side: drives the nybble stream, observes events.
  modport master (
    output compressed_trace__valid, compressed_trace__data,
    input  compressed_trace_ready,
    input  packed_trace__seq_valid, packed_trace__seq,
    input  packed_trace__nonseq_valid, packed_trace__nonseq,
    input  packed_trace__bkpt_valid, packed_trace__bkpt,
    input  packed_trace__data_valid, packed_trace__data_reason, packed_trace__data,
    input  packed_trace__compressed_data_num_bytes, packed_trace__compressed_data_nybble
  );

  modport slave (
    input  compressed_trace__valid, compressed_trace__data,
    output compressed_trace_ready,
    output packed_trace__seq_valid, packed_trace__seq,
    output packed_trace__nonseq_valid, packed_trace__nonseq,
    output packed_trace__bkpt_valid, packed_trace__bkpt,
    output packed_trace__data_valid, packed_trace__data_reason, packed_trace__data,
    output packed_trace__compressed_data_num_bytes, packed_trace__compressed_data_nybble
  );
endinterface

`default_nettype wire

// File: rtl/riscv_i32_trace_decompression.sv
// +----------------------------------------------------------------------------+
// | riscv_i32_trace_decompression                                              |
// | Nybble-stream trace decoder: 32-nybble buffer, one token per cycle.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module riscv_i32_trace_decompression (
  input  wire logic                      clk,
  input  wire logic                      reset,
  riscv_i32_trace_decompression_if.slave trace,
  output logic                           decode_error
);

  localparam logic [5:0] C_READY_MAX = 6'd16;
  localparam logic [4:0] C_WORD_MAX  = 5'd16;

  logic [127:0] r_buf;
  logic [5:0]   r_count;

  logic         r_seq_valid, r_nonseq_valid, r_bkpt_valid, r_data_valid;
  logic [2:0]   r_seq;
  logic [1:0]   r_nonseq;
  logic [3:0]   r_bkpt;
  logic         r_data_reason;
  logic [39:0]  r_data;
  logic [3:0]   r_num_bytes;
  logic         r_err;

  logic [3:0]   w_head;
  logic [3:0]   w_n1;
  logic [5:0]   w_len_e;
  logic [5:0]   w_consume;
  logic         w_seq_valid, w_nonseq_valid, w_bkpt_valid, w_data_valid;
  logic [2:0]   w_seq;
  logic [1:0]   w_nonseq;
  logic [3:0]   w_bkpt;
  logic         w_data_reason;
  logic [39:0]  w_data;
  logic [3:0]   w_num_bytes;
  logic         w_tok_err;

  logic         w_ready;
  logic         w_accept;
  logic         w_word_bad;
  logic [5:0]   w_add;
  logic [63:0]  w_mask;
  logic [5:0]   w_base;
  logic [127:0] w_append;
  logic [127:0] w_buf_next;
  logic [5:0]   w_count_next;

  assign w_head  = r_buf[3:0];
  assign w_n1    = r_buf[7:4];
  assign w_len_e = 6'd4 + {2'b00, w_n1[2:0], 1'b0};
  assign w_ready = (r_count <= C_READY_MAX);

  // Token decode from the buffer head; nothing is consumed until the whole token is present.
  always_comb begin
    w_consume      = '0;
    w_seq_valid    = 1'b0;
    w_seq          = '0;
    w_nonseq_valid = 1'b0;
    w_nonseq       = '0;
    w_bkpt_valid   = 1'b0;
    w_bkpt         = '0;
    w_data_valid   = 1'b0;
    w_data_reason  = 1'b0;
    w_data         = '0;
    w_num_bytes    = '0;
    w_tok_err      = 1'b0;
    if (r_count != 6'd0) begin
      if (w_head[3] == 1'b0) begin
        w_consume   = 6'd1;
        w_seq_valid = 1'b1;
        w_seq       = w_head[2:0];
      end else if (w_head[3:2] == 2'b10) begin
        w_consume      = 6'd1;
        w_nonseq_valid = 1'b1;
        w_nonseq       = w_head[1:0];
      end else if (w_head == 4'hC) begin
        w_consume = 6'd1;
        w_tok_err = 1'b1;
      end else if (w_head == 4'hF) begin
        w_consume = 6'd1;
      end else if (r_count >= 6'd2) begin
        if (w_head == 4'hD) begin
          w_consume    = 6'd2;
          w_bkpt_valid = 1'b1;
          w_bkpt       = w_n1;
        end else if (w_n1[2:0] > 3'd4) begin
          w_consume = 6'd2;
          w_tok_err = 1'b1;
        end else if (r_count >= w_len_e) begin
          w_consume     = w_len_e;
          w_data_valid  = 1'b1;
          w_data_reason = w_n1[3];
          w_num_bytes   = {1'b0, w_n1[2:0]};
          case (w_n1[2:0])
            3'd0:    w_data = {32'b0, r_buf[15:8]};
            3'd1:    w_data = {24'b0, r_buf[23:8]};
            3'd2:    w_data = {16'b0, r_buf[31:8]};
            3'd3:    w_data = {8'b0,  r_buf[39:8]};
            default: w_data = r_buf[47:8];
          endcase
        end
      end
    end
  end

  assign w_accept   = (trace.compressed_trace__valid != 5'd0) && w_ready;
  assign w_word_bad = (trace.compressed_trace__valid > C_WORD_MAX);
  assign w_add      = (w_accept && !w_word_bad) ? {1'b0, trace.compressed_trace__valid} : 6'd0;
  assign w_base     = r_count - w_consume;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 16; i++) begin
      w_mask[i*4 +: 4] = (5'(i) < trace.compressed_trace__valid) ? 4'hF : 4'h0;
    end
  end

  // New nybbles land directly behind whatever survives this cycle's consumption.
  assign w_append     = {64'b0, trace.compressed_trace__data & w_mask} << {w_base, 2'b00};
  assign w_buf_next   = (r_buf >> {w_consume, 2'b00}) | ((w_add != 6'd0) ? w_append : 128'b0);
  assign w_count_next = w_base + w_add;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf          <= '0;
      r_count        <= '0;
      r_seq_valid    <= 1'b0;
      r_seq          <= '0;
      r_nonseq_valid <= 1'b0;
      r_nonseq       <= '0;
      r_bkpt_valid   <= 1'b0;
      r_bkpt         <= '0;
      r_data_valid   <= 1'b0;
      r_data_reason  <= 1'b0;
      r_data         <= '0;
      r_num_bytes    <= '0;
      r_err          <= 1'b0;
    end else begin
      r_buf          <= w_buf_next;
      r_count        <= w_count_next;
      r_seq_valid    <= w_seq_valid;
      r_seq          <= w_seq;
      r_nonseq_valid <= w_nonseq_valid;
      r_nonseq       <= w_nonseq;
      r_bkpt_valid   <= w_bkpt_valid;
      r_bkpt         <= w_bkpt;
      r_data_valid   <= w_data_valid;
      r_data_reason  <= w_data_reason;
      r_data         <= w_data;
      r_num_bytes    <= w_num_bytes;
      r_err          <= w_tok_err || (w_accept && w_word_bad);
    end
  end

  assign trace.compressed_trace_ready                  = w_ready;
  assign trace.packed_trace__seq_valid                 = r_seq_valid;
  assign trace.packed_trace__seq                       = r_seq;
  assign trace.packed_trace__nonseq_valid              = r_nonseq_valid;
  assign trace.packed_trace__nonseq                    = r_nonseq;
  assign trace.packed_trace__bkpt_valid                = r_bkpt_valid;
  assign trace.packed_trace__bkpt                      = r_bkpt;
  assign trace.packed_trace__data_valid                = r_data_valid;
  assign trace.packed_trace__data_reason               = r_data_reason;
  assign trace.packed_trace__data                      = r_data;
  assign trace.packed_trace__compressed_data_num_bytes = r_num_bytes;
  assign trace.packed_trace__compressed_data_nybble    = 3'b000;
  assign decode_error                                  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_riscv_i32_trace_decompression.sv
// +----------------------------------------------------------------------------+
// | tb_riscv_i32_trace_decompression                                           |
// | Directed self-checking bench for the trace decompressor.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_riscv_i32_trace_decompression;

  logic clk;
  logic reset;
  logic decode_error;
  int   n_checks;
  int   n_errors;

  riscv_i32_trace_decompression_if u_if ();

  riscv_i32_trace_decompression u_dut (
    .clk          (clk),
    .reset        (reset),
    .trace        (u_if),
    .decode_error (decode_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {seq_valid, nonseq_valid, bkpt_valid, data_valid, decode_error}
  function automatic logic [63:0] evt_flags();
    return {59'b0, u_if.packed_trace__seq_valid, u_if.packed_trace__nonseq_valid,
            u_if.packed_trace__bkpt_valid, u_if.packed_trace__data_valid, decode_error};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] v, input logic [63:0] d);
    u_if.compressed_trace__valid = v;
    u_if.compressed_trace__data  = d;
    step();
    u_if.compressed_trace__valid = 5'd0;
    u_if.compressed_trace__data  = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ev;
    int bad;
    int sent;
    logic saw_low;
    logic acc;

    n_checks = 0;
    n_errors = 0;
    u_if.compressed_trace__valid = 5'd0;
    u_if.compressed_trace__data  = 64'd0;
    reset = 1'b1;
    repeat (3) step();

    check("rst_ready", 64'(u_if.compressed_trace_ready), 64'd1);
    check("rst_evt", evt_flags(), 64'd0);
    check("rst_data", 64'(u_if.packed_trace__data), 64'd0);
    check("rst_nybble", 64'(u_if.packed_trace__compressed_data_nybble), 64'd0);
    reset = 1'b0;
    step();

    // Single seq token
    send(5'd1, 64'h5);
    check("seq_e0", evt_flags(), 64'd0);
    step();
    check("seq_evt", evt_flags(), 64'b10000);
    check("seq_val", 64'(u_if.packed_trace__seq), 64'd5);
    step();
    check("seq_once", evt_flags(), 64'd0);

    // seq, nonseq, bkpt on consecutive cycles
    send(5'd4, 64'h3DA6);
    step();
    check("mix_seq_evt", evt_flags(), 64'b10000);
    check("mix_seq_val", 64'(u_if.packed_trace__seq), 64'd6);
    step();
    check("mix_ns_evt", evt_flags(), 64'b01000);
    check("mix_ns_val", 64'(u_if.packed_trace__nonseq), 64'd2);
    step();
    check("mix_bk_evt", evt_flags(), 64'b00100);
    check("mix_bk_val", 64'(u_if.packed_trace__bkpt), 64'd3);
    step();
    check("mix_idle", evt_flags(), 64'd0);

    // Short data token
    send(5'd4, 64'h5A8E);
    check("d0_e0", evt_flags(), 64'd0);
    step();
    check("d0_evt", evt_flags(), 64'b00010);
    check("d0_reason", 64'(u_if.packed_trace__data_reason), 64'd1);
    check("d0_nbytes", 64'(u_if.packed_trace__compressed_data_num_bytes), 64'd0);
    check("d0_data", 64'(u_if.packed_trace__data), 64'h5A);
    step();
    check("d0_idle", evt_flags(), 64'd0);

    // Data token split across two words
    send(5'd3, 64'h41E);
    step();
    check("split_wait", evt_flags(), 64'd0);
    send(5'd3, 64'h321);
    step();
    check("split_evt", evt_flags(), 64'b00010);
    check("split_reason", 64'(u_if.packed_trace__data_reason), 64'd0);
    check("split_nbytes", 64'(u_if.packed_trace__compressed_data_num_bytes), 64'd1);
    check("split_data", 64'(u_if.packed_trace__data), 64'h3214);
    step();
    check("split_idle", evt_flags(), 64'd0);

    // Filler then seq
    send(5'd2, 64'h5F);
    step();
    check("fill_none", evt_flags(), 64'd0);
    step();
    check("fill_seq_evt", evt_flags(), 64'b10000);
    check("fill_seq_val", 64'(u_if.packed_trace__seq), 64'd5);
    step();

    // Backpressure: two full words of bkpt=1 tokens back-to-back
    ev = 0; bad = 0; sent = 0; saw_low = 1'b0;
    u_if.compressed_trace__valid = 5'd16;
    u_if.compressed_trace__data  = 64'h1D1D1D1D1D1D1D1D;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = u_if.compressed_trace_ready && (u_if.compressed_trace__valid != 5'd0);
      step();
      if (acc) sent++;
      if (sent >= 2) begin
        u_if.compressed_trace__valid = 5'd0;
        u_if.compressed_trace__data  = 64'd0;
      end
      if (!u_if.compressed_trace_ready) saw_low = 1'b1;
      if (u_if.packed_trace__bkpt_valid) begin
        ev++;
        if (u_if.packed_trace__bkpt != 4'd1) bad++;
      end
      if (evt_flags() & 64'b11011) bad++;
    end
    check("bp_sent", 64'(sent), 64'd2);
    check("bp_ready_low", 64'(saw_low), 64'd1);
    check("bp_events", 64'(ev), 64'd16);
    check("bp_bad", 64'(bad), 64'd0);
    check("bp_ready_end", 64'(u_if.compressed_trace_ready), 64'd1);

    // Illegal token 0xC
    send(5'd1, 64'hC);
    step();
    check("tokc_err", evt_flags(), 64'b00001);
    step();
    check("tokc_idle", evt_flags(), 64'd0);

    // Illegal data length L=5
    send(5'd2, 64'h5E);
    step();
    check("badL_err", evt_flags(), 64'b00001);
    step();
    check("badL_idle", evt_flags(), 64'd0);

    // Illegal word valid count
    send(5'd20, 64'h5);
    check("badw_err", evt_flags(), 64'b00001);
    step();
    check("badw_drop", evt_flags(), 64'd0);
    step();
    check("badw_idle", evt_flags(), 64'd0);

    // Reset in the middle of a token
    send(5'd3, 64'h41E);
    step();
    reset = 1'b1;
    #1;
    check("mrst_evt", evt_flags(), 64'd0);
    check("mrst_ready", 64'(u_if.compressed_trace_ready), 64'd1);
    check("mrst_data", 64'(u_if.packed_trace__data), 64'd0);
    step();
    reset = 1'b0;
    step();
    send(5'd1, 64'h5);
    step();
    check("mrst_seq_evt", evt_flags(), 64'b10000);
    check("mrst_seq_val", 64'(u_if.packed_trace__seq), 64'd5);
    step();
    check("mrst_idle", evt_flags(), 64'd0);
    step();
    check("mrst_idle2", evt_flags(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_i32_trace_decompression.md
RISCV_I32_TRACE_DECOMPRESSION -- requirements
Module: riscv_i32_trace_decompression

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk  in  1  clock, all state on rising edge`.
REQ-002 It SHALL have `reset  in  1  asynchronous active-high reset`.
REQ-003 It SHALL have `compressed_trace__valid  in  5  number of valid nybbles in the input word; 0 means no word offered`.
REQ-004 It SHALL have `compressed_trace__data  in  64  nybble stream, LSB nybble first`.
REQ-005 It SHALL have `compressed_trace_ready  out  1  input word accepted on an edge where valid!=0 and ready=1`.
REQ-006 It SHALL have `packed_trace__seq_valid / __seq  out  1 / 3  sequential-instruction event`.
REQ-007 It SHALL have `packed_trace__nonseq_valid / __nonseq  out  1 / 2  non-sequential event`.
REQ-008 It SHALL have `packed_trace__bkpt_valid / __bkpt  out  1 / 4  breakpoint event`.
REQ-009 It SHALL have `packed_trace__data_valid, __data_reason, __data  out  1, 1, 40  data event`.
REQ-010 It SHALL have `packed_trace__compressed_data_num_bytes  out  4  data length code L, zero-extended`.
REQ-011 It SHALL have `packed_trace__compressed_data_nybble  out  3  always 0`.
REQ-012 It SHALL have `decode_error  out  1  one-cycle pulse on an illegal token or word`.

Function
REQ-013 Buffer: 32-nybble FIFO-ordered shift buffer (128 bits) with a 6-bit count (0..32).
REQ-014 Ready: compressed_trace_ready SHALL equal 1 exactly when the registered count <= 16.
REQ-015 Accept: an accepted word SHALL append its valid nybbles, in order, at buffer index (count - consumed_this_cycle).
REQ-016 Next count: new count SHALL equal count - consumed + accepted_nybbles, with no loss or duplication.
REQ-017 Word validity: input valid values 17..31 SHALL be illegal; such a word is accepted, dropped, and pulses decode_error.
REQ-018 Decode rate: at most one token SHALL be decoded per cycle, from the buffer head (nybble 0).
REQ-019 Token 0x0..0x7: length 1; seq event, seq=head[2:0].
REQ-020 Token 0x8..0xB: length 1; nonseq event, nonseq=head[1:0].
REQ-021 Token 0xD: length 2; bkpt event, bkpt=nybble1.
REQ-022 Token 0xE: header nybble1 = {reason, L[2:0]}; length 4+2*L.
- Data event: data = the next 2*(L+1) nybbles, LSB first, upper bits zero; data_reason = reason; num_bytes = {0, L}.
- L = 5..7 is illegal: drop 2 nybbles and pulse decode_error.
REQ-023 Token 0xF: filler; drop 1 nybble with no event and no error.
REQ-024 Token 0xC: illegal; drop 1 nybble and pulse decode_error.
REQ-025 Incomplete token: if count < the required token length, nothing SHALL be consumed and no event emitted; decoding waits for more nybbles.
REQ-026 Outputs: all packed_trace outputs SHALL be registered; each *_valid is a single-cycle pulse; at most one *_valid is high per cycle; non-valid fields are 0.
REQ-027 Latency: a token that is complete in the buffer after edge E SHALL produce its event on the outputs after edge E+1.
- A token completed by the word accepted at edge E0 is therefore output after E0+1.
REQ-028 Ordering: events SHALL be emitted in stream order, so an encoder word yields seq, nonseq, bkpt, data in that order.
REQ-029 Empty buffer: count 0 SHALL produce no event and no error.

Reset
REQ-030 While reset is high:
- count = 0 and the buffer is cleared;
- all *_valid, decode_error and data fields = 0;
- compressed_trace_ready = 1 (count 0).
REQ-031 Reset mid-token SHALL discard the partial token; decoding after reset restarts at the next accepted word.

Verification
REQ-032 valid=1, data=0x5 -> seq_valid=1, seq=5, one cycle only, two edges after acceptance.
REQ-033 valid=4, data=0x3DA6 -> on consecutive cycles: seq=6, then nonseq=2, then bkpt=3.
REQ-034 valid=4, data=0x5A8E -> data_valid=1, data_reason=1, num_bytes=0, data=0x5A.
REQ-035 Split token: valid=3 data=0x41E, then valid=3 data=0x321 -> no event until the second word; then data_valid=1, reason=0, num_bytes=1, data=0x3214.
REQ-036 Backpressure: two back-to-back words, valid=16, data=0x1D1D...1D (8 bkpt tokens each).
- Response: ready drops while count > 16; 16 bkpt=1 events are emitted in order; nothing lost.
REQ-037 Errors and reset:
- Nybble 0xC -> decode_error pulse, no event.
- valid=20 -> decode_error pulse, word dropped.
- Reset asserted after 0x41E -> all outputs 0, ready=1; a following 0x5 word yields seq=5 only.
